// File: rtl/phase_avg_filter.sv
// Window averager for phase-detector samples: reports mean and spread of each
// 2^LOG2_N-sample window and flags lock once consecutive means agree.
module phase_avg_filter #(
    parameter int unsigned LOG2_N     = 3,
    parameter int unsigned LOCK_TOL   = 4,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [9:0] i_phase,
    input  logic       i_valid,
    input  logic       i_clear,
    output logic [9:0] o_avg,
    output logic [9:0] o_spread,
    output logic       o_avg_valid,
    output logic       o_locked
);

    localparam int unsigned AccW = 10 + LOG2_N;

    typedef enum logic {StNoHist, StTrack} state_t;

    state_t              r_state;
    logic [AccW-1:0]     r_acc;
    logic [LOG2_N-1:0]   r_cnt;
    logic [9:0]          r_min;
    logic [9:0]          r_max;
    logic [9:0]          r_prev;
    logic [3:0]          r_stable;
    logic [9:0]          r_avg;
    logic [9:0]          r_spread;
    logic                r_avg_valid;
    logic                r_locked;

    logic [AccW-1:0]     w_acc_next;
    logic [AccW-1:0]     w_shifted;
    logic [9:0]          w_mean;
    logic [9:0]          w_min_next;
    logic [9:0]          w_max_next;
    logic [9:0]          w_diff;
    logic [3:0]          w_stable_next;
    logic                w_last;

    always_comb begin
        w_acc_next = r_acc + AccW'(i_phase);
        w_shifted  = w_acc_next >> LOG2_N;
        w_mean     = w_shifted[9:0];
        w_min_next = (i_phase < r_min) ? i_phase : r_min;
        w_max_next = (i_phase > r_max) ? i_phase : r_max;
        w_last     = &r_cnt;
        w_diff     = (w_mean >= r_prev) ? (w_mean - r_prev) : (r_prev - w_mean);
        if (w_diff <= 10'(LOCK_TOL)) begin
            // Saturate so a long stable run does not wrap back below LOCK_COUNT.
            w_stable_next = (r_stable == 4'(LOCK_COUNT)) ? r_stable : r_stable + 4'd1;
        end else begin
            w_stable_next = 4'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StNoHist;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_min       <= 10'h3ff;
            r_max       <= 10'd0;
            r_prev      <= 10'd0;
            r_stable    <= 4'd0;
            r_avg       <= 10'd0;
            r_spread    <= 10'd0;
            r_avg_valid <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (i_clear) begin
                // Clear drops any coincident sample; avg/spread keep last values.
                r_state  <= StNoHist;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_min    <= 10'h3ff;
                r_max    <= 10'd0;
                r_prev   <= 10'd0;
                r_stable <= 4'd0;
                r_locked <= 1'b0;
            end else if (i_valid) begin
                if (w_last) begin
                    r_avg       <= w_mean;
                    r_spread    <= w_max_next - w_min_next;
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_min       <= 10'h3ff;
                    r_max       <= 10'd0;
                    r_prev      <= w_mean;
                    unique case (r_state)
                        StNoHist: begin
                            r_state  <= StTrack;
                            r_stable <= 4'd0;
                            r_locked <= 1'b0;
                        end
                        StTrack: begin
                            r_stable <= w_stable_next;
                            r_locked <= (w_stable_next == 4'(LOCK_COUNT));
                        end
                        default: r_state <= StNoHist;
                    endcase
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    r_min <= w_min_next;
                    r_max <= w_max_next;
                end
            end
        end
    end

    assign o_avg       = r_avg;
    assign o_spread    = r_spread;
    assign o_avg_valid = r_avg_valid;
    assign o_locked    = r_locked;

endmodule

// File: tb/tb_phase_avg_filter.sv
// Bench for phase_avg_filter: directed scenarios plus random traffic, every cycle
// compared against a queue-based window/lock model.
module tb_phase_avg_filter;

    localparam int unsigned LOG2_N     = 3;
    localparam int unsigned LOCK_TOL   = 4;
    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned N          = 1 << LOG2_N;

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic [9:0] i_phase;
    logic       i_valid;
    logic       i_clear;
    logic [9:0] o_avg;
    logic [9:0] o_spread;
    logic       o_avg_valid;
    logic       o_locked;

    phase_avg_filter #(
        .LOG2_N     (LOG2_N),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_phase     (i_phase),
        .i_valid     (i_valid),
        .i_clear     (i_clear),
        .o_avg       (o_avg),
        .o_spread    (o_spread),
        .o_avg_valid (o_avg_valid),
        .o_locked    (o_locked)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_pulse = 0;

    // Reference model state
    int q[$];
    int m_avg = 0, m_spread = 0, m_valid = 0, m_locked = 0;
    int m_has_prev = 0, m_prev = 0, m_stable = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_avg = 0; m_spread = 0; m_valid = 0; m_locked = 0;
        m_has_prev = 0; m_prev = 0; m_stable = 0;
    endtask

    task automatic model_step(input int valid, input int phase, input int clear);
        int sum, mn, mx, mean, diff;
        m_valid = 0;
        if (clear != 0) begin
            q.delete();
            m_has_prev = 0; m_prev = 0; m_stable = 0; m_locked = 0;
        end else if (valid != 0) begin
            q.push_back(phase);
            if (q.size() == N) begin
                sum = 0; mn = 1023; mx = 0;
                foreach (q[k]) begin
                    sum += q[k];
                    if (q[k] < mn) mn = q[k];
                    if (q[k] > mx) mx = q[k];
                end
                mean = sum / N;
                m_avg = mean;
                m_spread = mx - mn;
                m_valid = 1;
                if (m_has_prev != 0) begin
                    diff = (mean > m_prev) ? mean - m_prev : m_prev - mean;
                    if (diff <= LOCK_TOL) m_stable = (m_stable < LOCK_COUNT) ? m_stable + 1 : m_stable;
                    else m_stable = 0;
                end
                m_has_prev = 1;
                m_prev = mean;
                m_locked = (m_stable == LOCK_COUNT) ? 1 : 0;
                q.delete();
            end
        end
    endtask

    // Drive one cycle, advance model, sample 1ns after the edge.
    task automatic cycle(input int valid, input int phase, input int clear);
        i_valid = valid[0];
        i_phase = phase[9:0];
        i_clear = clear[0];
        model_step(valid, phase, clear);
        @(posedge i_clk);
        #1;
        if (o_avg_valid) n_pulse++;
        check_eq("avg_valid", int'(o_avg_valid), m_valid);
        check_eq("avg", int'(o_avg), m_avg);
        check_eq("spread", int'(o_spread), m_spread);
        check_eq("locked", int'(o_locked), m_locked);
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic send(input int phase, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) cycle(0, int'($urandom_range(1023, 0)), 0);
        cycle(1, phase, 0);
    endtask

    task automatic send_window(input int value, input int max_gap);
        for (int k = 0; k < N; k++) send(value, max_gap);
    endtask

    task automatic apply_reset();
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_rstn  = 1'b0;
        #1;
        check_eq("rst_avg", int'(o_avg), 0);
        check_eq("rst_spread", int'(o_spread), 0);
        check_eq("rst_valid", int'(o_avg_valid), 0);
        check_eq("rst_locked", int'(o_locked), 0);
        repeat (2) @(posedge i_clk);
        #3;
        i_rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        int base;
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_phase = 10'd0;
        #12;
        check_eq("reset_avg", int'(o_avg), 0);
        check_eq("reset_spread", int'(o_spread), 0);
        check_eq("reset_valid", int'(o_avg_valid), 0);
        check_eq("reset_locked", int'(o_locked), 0);
        i_rstn = 1'b1;
        model_reset();

        // Constant window with random gaps
        n_pulse = 0;
        send_window(100, 3);
        repeat (2) cycle(0, 0, 0);
        check_eq("gap_pulses", n_pulse, 1);
        check_eq("gap_avg", int'(o_avg), 100);

        // Ramp then full-scale, back to back
        for (int k = 0; k < 8; k++) cycle(1, k, 0);
        check_eq("ramp_avg", int'(o_avg), 3);
        check_eq("ramp_spread", int'(o_spread), 7);
        for (int k = 0; k < 8; k++) cycle(1, 1023, 0);
        check_eq("max_avg", int'(o_avg), 1023);
        check_eq("max_spread", int'(o_spread), 0);

        // Lock acquisition, hold within tolerance, loss beyond it
        cycle(0, 0, 1);
        for (int w = 0; w < 5; w++) send_window(200, 1);
        check_eq("lock_on", int'(o_locked), 1);
        send_window(204, 0);
        check_eq("lock_hold", int'(o_locked), 1);
        send_window(210, 0);
        check_eq("lock_lost", int'(o_locked), 0);

        // Clear wins over a coincident sample
        n_pulse = 0;
        for (int k = 0; k < 5; k++) cycle(1, 300, 0);
        cycle(1, 999, 1);
        send_window(50, 0);
        cycle(0, 0, 0);
        check_eq("clr_pulses", n_pulse, 1);
        check_eq("clr_avg", int'(o_avg), 50);
        check_eq("clr_locked", int'(o_locked), 0);

        // Reset from locked state mid-window
        for (int w = 0; w < 5; w++) send_window(200, 0);
        check_eq("pre_rst_lock", int'(o_locked), 1);
        for (int k = 0; k < 3; k++) cycle(1, 200, 0);
        apply_reset();
        send_window(40, 1);
        check_eq("post_rst_avg", int'(o_avg), 40);
        check_eq("post_rst_locked", int'(o_locked), 0);

        // Random traffic near a drifting base to exercise lock gain/loss
        base = 500;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99, 0) < 3) base = int'($urandom_range(1000, 0));
            if ($urandom_range(199, 0) == 0) cycle(int'($urandom_range(1, 0)), base, 1);
            else if ($urandom_range(3, 0) == 0) cycle(0, int'($urandom_range(1023, 0)), 0);
            else cycle(1, base + int'($urandom_range(6, 0)) + ((base > 1010) ? -10 : 0), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
